stopwatch_button_fsm: RTL and testbench
=======================================

Name: stopwatch_button_fsm

Overview:
- Upstream control stage of the stopwatch. Converts the raw push-button into the control signals consumed by the increment clock-enable and the BCD counter: `prepare_start` pulse, `clear` pulse and `running` level.
- Internals: 2-FF synchroniser, counter-based debounce, and a three-state run/stop/clear FSM.
- A long press while stopped clears the count; a short press toggles run/stop.

Parameters:
- DBNC_DIV, 500_000, consecutive clk cycles the synchronised input must differ from the debounced level before that level flips (5 ms at 100 MHz).
- LONG_CYCLES, 100_000_000, debounced-press duration in clk cycles that counts as a long press (1 s at 100 MHz).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- button  input  1  raw button, active-high (already inverted by the top level), asynchronous to clk.
- prepare_start  output  1  one-cycle pulse; resets the increment clock-enable phase.
- clear  output  1  one-cycle pulse; zeroes the BCD counter.
- running  output  1  level; high while the counter is allowed to increment.
- pressed  output  1  debounced button level, for status/LED use.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - sync FFs=0, debounce counter=0, pressed=0, hold counter=0.
  - state=IDLE; prepare_start=0, clear=0, running=0.
  - All outputs are registered.
- Synchroniser: two flops; sync = button delayed 2 cycles.
- Debounce:
  - If sync==pressed, the counter resets to 0.
  - Otherwise the counter increments. When it equals DBNC_DIV-1 with sync still differing, `pressed` toggles on the next edge and the counter resets.
  - Net effect: `pressed` flips DBNC_DIV cycles after sync first differs continuously.
  - Any bounce back to equality restarts the count.
  - Counter width is clog2(DBNC_DIV).
- Edge detect:
  - press_evt = pressed rises; release_evt = pressed falls.
  - Both are single-cycle, derived from a registered copy of `pressed`.
- Hold counter:
  - Clears on press_evt; increments each cycle while pressed=1.
  - Saturates at LONG_CYCLES; never wraps.
  - long_evt is a single-cycle event when the counter reaches LONG_CYCLES-1.
  - Width is clog2(LONG_CYCLES+1).
- FSM states: IDLE (cleared, not running), RUN, STOP, HOLD (stopped, button held, decision pending).
  - IDLE --press_evt--> RUN: prepare_start=1 for one cycle; running=1 from the same cycle.
  - RUN --press_evt--> STOP: running=0 in the next cycle. No pulse.
  - STOP --press_evt--> HOLD: running stays 0.
  - HOLD --release_evt before long_evt--> RUN: prepare_start pulse, running=1 (resume without clearing).
  - HOLD --long_evt--> IDLE: clear pulse; running stays 0.
  - Release after a long press is ignored. IDLE never issues prepare_start on release.
  - RUN and IDLE ignore long_evt: holding in RUN keeps it stopped after the initial press; holding in IDLE keeps it running.
  - release_evt in IDLE, RUN or STOP has no effect.
- Output timing: pulse outputs assert exactly one cycle after the cycle in which press_evt/release_evt/long_evt is high. prepare_start and clear are never high in the same cycle.
- Simultaneous events: long_evt and release_evt cannot coincide because release clears the hold path. If they are ever both high in HOLD, long_evt wins (clear).
- Reset mid-operation: any state returns immediately to IDLE with all outputs 0. No clear pulse is generated; downstream blocks have their own reset.

Test Plan (DBNC_DIV=4, LONG_CYCLES=20 for sim):
- Reset then idle -> running=0, clear=0, prepare_start=0, pressed=0 for 50 cycles.
- Clean press held 10 cycles from IDLE -> pressed rises 2+4 cycles after button; prepare_start pulses exactly 1 cycle; running=1 and stays 1 after release.
- Bounce: button toggles 1,0,1,0 with 2-cycle widths, then stable 1 -> pressed rises only 4 cycles after the final stable edge; exactly one prepare_start.
- RUN, press 8 cycles, release; press 8 cycles, release -> running falls after the first press; second release gives one prepare_start pulse, running=1, and no clear.
- STOP, press held 40 cycles -> clear pulses once exactly 20 cycles after pressed rose; running=0; release gives no pulse; state IDLE (next press starts).
- reset_n pulsed low mid-HOLD -> all outputs 0 asynchronously; after release, a new press yields prepare_start (IDLE behaviour).

Source files
------------

// File: rtl/stopwatch_button_fsm.sv
// Stopwatch push-button front end: synchroniser, counter debounce, long-press
// timer and the run/stop/clear FSM producing prepare_start, clear and running.
module stopwatch_button_fsm #(
  parameter int DBNC_DIV    = 500_000,
  parameter int LONG_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button,
  output logic prepare_start,
  output logic clear,
  output logic running,
  output logic pressed
);
  localparam int DW = (DBNC_DIV > 1) ? $clog2(DBNC_DIV) : 1;
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DBNC_LAST = DW'(DBNC_DIV - 1);
  localparam logic [HW-1:0] LONG_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP, HOLD} state_e;

  logic          sync1_q, sync2_q;
  logic [DW-1:0] dbnc_cnt_q, dbnc_cnt_d;
  logic          pressed_q, pressed_d, pressed_prev_q;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  state_e        state_q, state_d;
  logic          prepare_q, prepare_d;
  logic          clear_q, clear_d;
  logic          running_q, running_d;
  logic          press_evt, release_evt, long_evt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      dbnc_cnt_q     <= '0;
      pressed_q      <= 1'b0;
      pressed_prev_q <= 1'b0;
      hold_cnt_q     <= '0;
      state_q        <= IDLE;
      prepare_q      <= 1'b0;
      clear_q        <= 1'b0;
      running_q      <= 1'b0;
    end else begin
      sync1_q        <= button;
      sync2_q        <= sync1_q;
      dbnc_cnt_q     <= dbnc_cnt_d;
      pressed_q      <= pressed_d;
      pressed_prev_q <= pressed_q;
      hold_cnt_q     <= hold_cnt_d;
      state_q        <= state_d;
      prepare_q      <= prepare_d;
      clear_q        <= clear_d;
      running_q      <= running_d;
    end
  end

  // Any return of sync to the debounced level restarts the qualification count.
  always_comb begin
    dbnc_cnt_d = '0;
    pressed_d  = pressed_q;
    if (sync2_q != pressed_q) begin
      if (dbnc_cnt_q == DBNC_LAST) begin
        pressed_d = ~pressed_q;
      end else begin
        dbnc_cnt_d = dbnc_cnt_q + DW'(1);
      end
    end
  end

  assign press_evt   = pressed_q & ~pressed_prev_q;
  assign release_evt = ~pressed_q & pressed_prev_q;

  // Held at zero while released, so the press_evt cycle is the first counted
  // held cycle; long_evt then lands LONG_CYCLES edges after pressed rose.
  always_comb begin
    hold_cnt_d = '0;
    if (pressed_q) begin
      hold_cnt_d = (hold_cnt_q == LONG_MAX) ? hold_cnt_q : hold_cnt_q + HW'(1);
    end
  end

  assign long_evt = pressed_q & (hold_cnt_q == LONG_LAST);

  always_comb begin
    state_d   = state_q;
    prepare_d = 1'b0;
    clear_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_evt) begin
          state_d   = RUN;
          prepare_d = 1'b1;
        end
      end
      RUN: begin
        if (press_evt) state_d = STOP;
      end
      STOP: begin
        if (press_evt) state_d = HOLD;
      end
      HOLD: begin
        if (long_evt) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end else if (release_evt) begin
          state_d   = RUN;
          prepare_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
  end

  assign prepare_start = prepare_q;
  assign clear         = clear_q;
  assign running       = running_q;
  assign pressed       = pressed_q;

endmodule

// File: tb/tb_stopwatch_button_fsm.sv
// Self-checking bench for stopwatch_button_fsm: directed scenarios plus random
// button activity, all compared against an event-timestamp reference model.
module tb_stopwatch_button_fsm;
  localparam int DBNC_DIV    = 4;
  localparam int LONG_CYCLES = 20;

  logic clk = 1'b0;
  logic reset_n;
  logic button = 1'b0;
  logic prepare_start, clear, running, pressed;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stopwatch_button_fsm #(.DBNC_DIV(DBNC_DIV), .LONG_CYCLES(LONG_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n), .button(button),
    .prepare_start(prepare_start), .clear(clear), .running(running), .pressed(pressed)
  );

  // Reference: pressed flips once the last DBNC_DIV synchronised samples all
  // disagree with it; events are derived from timestamps of pressed edges.
  bit bq[$];
  bit sq[$];
  bit m_pr = 0, m_prep = 0, m_clr = 0, m_run = 0;
  int m_mode = 0;  // 0 cleared, 1 running, 2 stopped, 3 stopped-and-held
  int edge_n = 0, rise_at = -100, fall_at = -100;

  always @(posedge clk or negedge reset_n) begin : model
    bit s, flip, pe, re, le, pr_pre;
    if (!reset_n) begin
      bq = {1'b0, 1'b0};
      sq.delete();
      m_pr = 0; m_prep = 0; m_clr = 0; m_run = 0;
      m_mode = 0; edge_n = 0; rise_at = -100; fall_at = -100;
    end else begin
      edge_n++;
      s = bq[bq.size()-2];
      bq.push_back(button);
      if (bq.size() > 3) void'(bq.pop_front());
      sq.push_back(s);
      if (sq.size() > DBNC_DIV) void'(sq.pop_front());
      pr_pre = m_pr;
      pe = (edge_n - rise_at == 1);
      re = (edge_n - fall_at == 1);
      le = pr_pre && (edge_n - rise_at == LONG_CYCLES);
      flip = (sq.size() == DBNC_DIV);
      foreach (sq[i]) if (sq[i] == pr_pre) flip = 0;
      if (flip) begin
        m_pr = ~pr_pre;
        if (m_pr) rise_at = edge_n; else fall_at = edge_n;
      end
      m_prep = 0; m_clr = 0;
      case (m_mode)
        0: if (pe) begin m_mode = 1; m_prep = 1; end
        1: if (pe) m_mode = 2;
        2: if (pe) m_mode = 3;
        default: if (le) begin m_mode = 0; m_clr = 1; end
                 else if (re) begin m_mode = 1; m_prep = 1; end
      endcase
      m_run = (m_mode == 1);
    end
  end

  task automatic do_reset();
    button = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    button  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({prepare_start, clear, running, pressed} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: got %b expected 0000", {prepare_start, clear, running, pressed});
    end
    reset_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      checks++;
      if ({prepare_start, clear, running, pressed} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_quiet cyc %0d: got %b expected 0000", c, {prepare_start, clear, running, pressed});
      end
    end
  endtask

  task automatic test_clean_press();
    int rise_iter = -1, preps = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if ({prepare_start, clear, running, pressed} !== {m_prep, m_clr, m_run, m_pr}) begin
        errors++;
        $display("FAIL clean_press cyc %0d: got %b expected %b", c, {prepare_start, clear, running, pressed}, {m_prep, m_clr, m_run, m_pr});
      end
      if (pressed && rise_iter < 0) rise_iter = c;
      if (prepare_start) preps++;
      button = (c < 10);
    end
    checks++;
    if (rise_iter !== 6) begin errors++; $display("FAIL clean_press_latency: got %0d expected 6", rise_iter); end
    checks++;
    if (preps !== 1) begin errors++; $display("FAIL clean_press_prep_count: got %0d expected 1", preps); end
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL clean_press_running: got %b expected 1", running); end
  endtask

  task automatic test_run_stop_resume();
    int preps = 0, clrs = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      checks++;
      if ({prepare_start, clear, running, pressed} !== {m_prep, m_clr, m_run, m_pr}) begin
        errors++;
        $display("FAIL stop_press cyc %0d: got %b expected %b", c, {prepare_start, clear, running, pressed}, {m_prep, m_clr, m_run, m_pr});
      end
      if (prepare_start) preps++;
      if (clear) clrs++;
      button = (c < 8);
    end
    checks++;
    if ({running, preps[3:0], clrs[3:0]} !== 9'd0) begin
      errors++;
      $display("FAIL stop_result: got running=%b preps=%0d clears=%0d expected 0/0/0", running, preps, clrs);
    end
    preps = 0; clrs = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      checks++;
      if ({prepare_start, clear, running, pressed} !== {m_prep, m_clr, m_run, m_pr}) begin
        errors++;
        $display("FAIL resume_press cyc %0d: got %b expected %b", c, {prepare_start, clear, running, pressed}, {m_prep, m_clr, m_run, m_pr});
      end
      if (prepare_start) preps++;
      if (clear) clrs++;
      button = (c < 8);
    end
    checks++;
    if (preps !== 1 || clrs !== 0 || running !== 1'b1) begin
      errors++;
      $display("FAIL resume_result: got preps=%0d clears=%0d running=%b expected 1/0/1", preps, clrs, running);
    end
  endtask

  task automatic test_bounce();
    int rise_iter = -1, preps = 0;
    do_reset();
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      checks++;
      if ({prepare_start, clear, running, pressed} !== {m_prep, m_clr, m_run, m_pr}) begin
        errors++;
        $display("FAIL bounce cyc %0d: got %b expected %b", c, {prepare_start, clear, running, pressed}, {m_prep, m_clr, m_run, m_pr});
      end
      if (pressed && rise_iter < 0) rise_iter = c;
      if (prepare_start) preps++;
      button = (c < 8) ? ((c % 4) < 2) : (c < 20);
    end
    checks++;
    if (rise_iter !== 14) begin errors++; $display("FAIL bounce_latency: got %0d expected 14", rise_iter); end
    checks++;
    if (preps !== 1) begin errors++; $display("FAIL bounce_prep_count: got %0d expected 1", preps); end
  endtask

  task automatic test_long_clear();
    int rise_iter = -1, clr_iter = -1, preps = 0, clrs = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      checks++;
      if ({prepare_start, clear, running, pressed} !== {m_prep, m_clr, m_run, m_pr}) begin
        errors++;
        $display("FAIL long_stop cyc %0d: got %b expected %b", c, {prepare_start, clear, running, pressed}, {m_prep, m_clr, m_run, m_pr});
      end
      button = (c < 8);
    end
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      checks++;
      if ({prepare_start, clear, running, pressed} !== {m_prep, m_clr, m_run, m_pr}) begin
        errors++;
        $display("FAIL long_hold cyc %0d: got %b expected %b", c, {prepare_start, clear, running, pressed}, {m_prep, m_clr, m_run, m_pr});
      end
      if (pressed && rise_iter < 0) rise_iter = c;
      if (clear && clr_iter < 0) clr_iter = c;
      if (clear) clrs++;
      if (prepare_start || running) preps++;
      button = (c < 40);
    end
    checks++;
    if (clr_iter - rise_iter !== LONG_CYCLES) begin
      errors++;
      $display("FAIL long_clear_delay: got %0d expected %0d", clr_iter - rise_iter, LONG_CYCLES);
    end
    checks++;
    if (clrs !== 1 || preps !== 0) begin
      errors++;
      $display("FAIL long_clear_pulses: got clears=%0d prep_or_run=%0d expected 1/0", clrs, preps);
    end
    preps = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (prepare_start) preps++;
      button = (c < 8);
    end
    checks++;
    if (preps !== 1 || running !== 1'b1) begin
      errors++;
      $display("FAIL restart_after_clear: got preps=%0d running=%b expected 1/1", preps, running);
    end
  endtask

  task automatic test_reset_mid_hold();
    int preps = 0;
    for (int c = 0; c < 37; c++) begin
      @(negedge clk);
      checks++;
      if ({prepare_start, clear, running, pressed} !== {m_prep, m_clr, m_run, m_pr}) begin
        errors++;
        $display("FAIL pre_hold cyc %0d: got %b expected %b", c, {prepare_start, clear, running, pressed}, {m_prep, m_clr, m_run, m_pr});
      end
      button = (c < 8) || (c >= 25);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({prepare_start, clear, running, pressed} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got %b expected 0000", {prepare_start, clear, running, pressed});
    end
    button = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      checks++;
      if ({prepare_start, clear, running, pressed} !== {m_prep, m_clr, m_run, m_pr}) begin
        errors++;
        $display("FAIL post_reset cyc %0d: got %b expected %b", c, {prepare_start, clear, running, pressed}, {m_prep, m_clr, m_run, m_pr});
      end
      if (prepare_start) preps++;
      button = (c >= 10) && (c < 18);
    end
    checks++;
    if (preps !== 1 || running !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_start: got preps=%0d running=%b expected 1/1", preps, running);
    end
  endtask

  task automatic test_random();
    logic level = 1'b0;
    int len;
    for (int seg = 0; seg < 70; seg++) begin
      level = ~level;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 32);
      for (int k = 0; k < len; k++) begin
        @(negedge clk);
        checks++;
        if ({prepare_start, clear, running, pressed} !== {m_prep, m_clr, m_run, m_pr}) begin
          errors++;
          $display("FAIL random seg %0d: got %b expected %b", seg, {prepare_start, clear, running, pressed}, {m_prep, m_clr, m_run, m_pr});
        end
        button = level;
      end
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if ({prepare_start, clear, running, pressed} !== {m_prep, m_clr, m_run, m_pr}) begin
        errors++;
        $display("FAIL random_drain cyc %0d: got %b expected %b", c, {prepare_start, clear, running, pressed}, {m_prep, m_clr, m_run, m_pr});
      end
      button = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish before 1000000");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_clean_press();
    test_run_stop_resume();
    test_bounce();
    test_long_clear();
    test_reset_mid_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
